// File: rtl/mul_issue_arbiter_pkg.sv
// Shared types for integer issue into the pipelined multiplier.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package mul_issue_arbiter_pkg;

    localparam int SQN_W = 7;
    localparam int TAG_W = 7;

    // Stage count of the Multiply unit and the resulting issue-to-result latency
    localparam int MUL_NUM_STAGES = 2;
    localparam int MUL_LAT        = MUL_NUM_STAGES + 2;

    typedef logic [SQN_W-1:0] SqN;
    typedef logic [TAG_W-1:0] Tag;

    typedef struct packed {
        logic        valid;
        Tag          tagDst;
        SqN          sqN;
        logic [31:0] srcA;
        logic [31:0] srcB;
        logic [1:0]  opcode;
    } EX_UOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    // One slot of the in-flight tracker: just enough to wake and to flush
    typedef struct packed {
        logic valid;
        Tag   tagDst;
        SqN   sqN;
    } TrkEntry;

    // True when x is strictly younger than a taken mispredicting branch.
    // Sequence numbers wrap, so age is the sign of the modular difference.
    function automatic logic is_killed(input SqN x, input BranchProv br);
        SqN d;
        d = x - br.sqN;
        return br.taken && !d[SQN_W-1] && (d != '0);
    endfunction

endpackage

// File: rtl/mul_wake_tracker.sv
// Shadows ops inside the multiplier to emit an early wakeup and an in-flight count.
// Latency: wake is registered, LAT-1 cycles after the op sat in the multiplier input register.
// Backpressure: none; the multiplier never stalls, so the shift register always advances.
module mul_wake_tracker
    import mul_issue_arbiter_pkg::*;
#(
    parameter  int LAT   = MUL_LAT,
    localparam int CNT_W = $clog2(LAT + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  BranchProv        IN_branch,
    input  TrkEntry          IN_ent,
    output logic             OUT_wakeValid,
    output Tag               OUT_wakeTag,
    output logic [CNT_W-1:0] OUT_count
);

    // Entry k holds an op k+1 cycles after it was in the multiplier input register
    localparam int DEPTH = LAT - 1;
    // Wake is taken one slot early so the registered strobe leads the result by a cycle
    localparam int WAKE_IDX = LAT - 3;

    TrkEntry          trk_q [DEPTH];
    TrkEntry          trk_d [DEPTH];
    logic             wake_vld_q, wake_vld_d;
    Tag               wake_tag_q, wake_tag_d;
    logic [CNT_W-1:0] cnt;

    // Shift every entry one slot, dropping any op younger than a taken mispredict
    always_comb begin
        trk_d[0]       = IN_ent;
        trk_d[0].valid = IN_ent.valid && !is_killed(IN_ent.sqN, IN_branch);
        for (int k = 1; k < DEPTH; k++) begin
            trk_d[k]       = trk_q[k-1];
            trk_d[k].valid = trk_q[k-1].valid && !is_killed(trk_q[k-1].sqN, IN_branch);
        end
        wake_vld_d = trk_q[WAKE_IDX].valid && !is_killed(trk_q[WAKE_IDX].sqN, IN_branch);
        wake_tag_d = trk_q[WAKE_IDX].tagDst;
    end

    // Tracker and wake registers; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                trk_q[k] <= '0;
            end
            wake_vld_q <= 1'b0;
            wake_tag_q <= '0;
        end else begin
            trk_q      <= trk_d;
            wake_vld_q <= wake_vld_d;
            wake_tag_q <= wake_tag_d;
        end
    end

    // Population count of live tracker entries
    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + CNT_W'(trk_q[k].valid);
        end
    end

    assign OUT_wakeValid = wake_vld_q;
    assign OUT_wakeTag   = wake_tag_q;
    assign OUT_count     = cnt;

endmodule

// File: rtl/mul_issue_arbiter.sv
// Round-robin share of one pipelined multiplier between two issue ports, with early wakeup.
// Latency: 1 cycle from a winning candidate to OUT_uop; wake LAT-1 cycles after OUT_uop.
// Backpressure: a losing uop parks in a 1-entry hold; OUT_stall[i] mirrors that hold.
module mul_issue_arbiter
    import mul_issue_arbiter_pkg::*;
#(
    parameter  int MUL_STAGES = MUL_NUM_STAGES,
    localparam int LAT        = MUL_STAGES + 2,
    localparam int INFL_W     = $clog2(LAT + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  BranchProv         IN_branch,
    input  EX_UOp             IN_uop [1:0],
    output logic [1:0]        OUT_stall,
    output EX_UOp             OUT_uop,
    output logic              OUT_wakeValid,
    output Tag                OUT_wakeTag,
    output logic [INFL_W-1:0] OUT_inflight,
    output logic              OUT_idle
);

    EX_UOp             hold_q [2];
    EX_UOp             hold_d [2];
    EX_UOp             uop_q, uop_d;
    logic              rr_q, rr_d;

    EX_UOp             cand [2];
    logic [1:0]        elig;
    logic              grant_vld;
    logic              grant_port;
    logic [INFL_W-1:0] trk_cnt;

    // Pick a winner among held or fresh candidates; the loser is parked, flushed ops vanish
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand[i] = hold_q[i].valid ? hold_q[i] : IN_uop[i];
            elig[i] = cand[i].valid && !is_killed(cand[i].sqN, IN_branch);
        end

        grant_vld  = |elig;
        grant_port = (elig == 2'b11) ? rr_q : elig[1];

        uop_d       = cand[grant_port];
        uop_d.valid = grant_vld;
        rr_d        = grant_vld ? ~grant_port : rr_q;

        for (int i = 0; i < 2; i++) begin
            hold_d[i] = hold_q[i];
            if (hold_q[i].valid) begin
                // A held op that is not eligible can only have been flushed
                if ((grant_vld && grant_port == 1'(i)) || !elig[i]) begin
                    hold_d[i].valid = 1'b0;
                end
            end else if (elig[i] && !(grant_vld && grant_port == 1'(i))) begin
                hold_d[i] = IN_uop[i];
            end
        end
    end

    // Hold buffers, multiplier input register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '{default: '0};
            uop_q  <= '0;
            rr_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            uop_q  <= uop_d;
            rr_q   <= rr_d;
        end
    end

    mul_wake_tracker #(
        .LAT (LAT)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .IN_branch     (IN_branch),
        .IN_ent        ('{valid: uop_q.valid, tagDst: uop_q.tagDst, sqN: uop_q.sqN}),
        .OUT_wakeValid (OUT_wakeValid),
        .OUT_wakeTag   (OUT_wakeTag),
        .OUT_count     (trk_cnt)
    );

    assign OUT_stall    = {hold_q[1].valid, hold_q[0].valid};
    assign OUT_uop      = uop_q;
    assign OUT_inflight = INFL_W'(uop_q.valid) + trk_cnt;
    assign OUT_idle     = !(hold_q[0].valid || hold_q[1].valid || uop_q.valid) && (trk_cnt == '0);

    // A port must stay quiet while its hold is occupied; such an input would be lost
    for (genvar gi = 0; gi < 2; gi++) begin : g_proto
        a_no_input_while_held: assert property (
            @(posedge clk) disable iff (rst) !(hold_q[gi].valid && IN_uop[gi].valid)
        );
    end

endmodule

// File: doc/mul_issue_arbiter.md
Name: mul_issue_arbiter

Overview:
- Shares one pipelined Multiply unit between two integer issue ports.
- Two-way round-robin arbitration, with a 1-entry hold buffer per port so a losing uop is never dropped.
- Registers the granted uop into the multiplier input.
- Tracks in-flight ops to broadcast an early wakeup tag one cycle before the result appears.
- Applies branch-mispredict flushes to everything it holds.

Parameters:
- MUL_STAGES, 2, value of the multiplier's NUM_STAGES.
- LAT, MUL_STAGES+2, cycles from OUT_uop.valid to the multiplier's result valid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- IN_branch  in  BranchProv  mispredict; uses .taken and .sqN.
- IN_uop[1:0]  in  EX_UOp  per-port candidate; .valid qualifies it.
- OUT_stall[1:0]  out  2  port i must not present a valid uop while stall[i]=1.
- OUT_uop  out  EX_UOp  registered uop to Multiply.IN_uop; Multiply en is tied 1.
- OUT_wakeValid  out  1  early wakeup strobe.
- OUT_wakeTag  out  Tag  tagDst being woken.
- OUT_inflight  out  $clog2(LAT+2)  count of ops in OUT_uop plus the tracker.
- OUT_idle  out  1  holds empty, OUT_uop invalid, tracker empty.

Behaviour:
- Reset (async): clear hold[0..1].valid, OUT_uop.valid, all tracker valids and OUT_wakeValid; rr=0.
  - Resulting outputs: OUT_stall=0, OUT_inflight=0, OUT_idle=1.
  - Payload fields are don't-care.
- Kill predicate: kill(x) = IN_branch.taken && $signed(x.sqN - IN_branch.sqN) > 0. An op with sqN equal to the branch is kept.
- Candidate per port: cand[i] = hold[i].valid ? hold[i] : IN_uop[i].
  - cand[i] is eligible iff its valid bit is set and kill(cand[i]) is false.
- Grant:
  - One eligible candidate wins outright.
  - Two eligible candidates: port rr wins. After any grant to port g, rr <= ~g. rr is unchanged when nothing is granted.
- Next-cycle OUT_uop:
  - Holds the winner with valid=1, else valid=0.
  - The current OUT_uop is never retained; the multiplier always accepts.
- Hold update per port:
  - Hold granted, or killed -> hold.valid <= 0.
  - Hold empty, input eligible and not granted -> capture IN_uop[i].
  - Otherwise unchanged.
  - A valid IN_uop[i] presented while hold[i].valid=1 is a protocol violation: ignored, and flagged by a simulation assertion.
- OUT_stall[i] = hold[i].valid, driven from the register.
  - Latency 1: an input that loses at edge t sees stall during cycle t+1.
  - Maximum wait for a held uop is 1 cycle, by round-robin fairness.
- Tracker: shift register trk[0..LAT-2] holding {valid, tagDst, sqN}.
  - trk[0] <= OUT_uop's fields when OUT_uop.valid; trk[k+1] <= trk[k].
  - Any entry with kill true is cleared as it shifts.
  - OUT_wakeValid/OUT_wakeTag are registered from trk[LAT-3]. They therefore assert in cycle t+LAT-1, where t is the cycle OUT_uop.valid was high. This is exactly one cycle before Multiply's OUT_uop.valid.
  - An op killed at any point before the wake cycle produces no wake.
- OUT_inflight = OUT_uop.valid + number of valid trk entries. OUT_idle is the reduction of all valids.
- Simultaneous events:
  - Flush in the same cycle as a capture: the capture is suppressed if the input is killed.
  - Flush in the same cycle as a grant: a killed winner is ineligible, so the other port may win that cycle.
- Reset mid-operation clears everything; no wake is emitted afterwards.

Decomposition:
- Add MUL_LAT (derived from the Multiply stage count) to the shared package.
- Reuse EX_UOp, BranchProv, Tag and SqN from the package.
- Natural sub-module: mul_wake_tracker, covering the shift register, kill logic, wake output and count.

Test Plan (MUL_STAGES=2, LAT=4):
- Single uop (sqN=5, tag=9) on port 0, cycle 0:
  - OUT_uop.valid in cycle 1.
  - wake tag=9 in cycle 4.
  - Multiply result in cycle 5.
  - OUT_idle returns to 1 in cycle 5.
- Both ports valid every cycle for 6 cycles, rr=0, stall honoured:
  - Grants alternate 0,1,0,1,...
  - stall[1]=1 in cycle 1.
  - No uop is lost or duplicated; 6 issues in 7 cycles.
- Port 1 uop (sqN=12) held; branch taken with sqN=10 the next cycle:
  - Hold cleared, no OUT_uop for it, stall[1]=0 in the following cycle.
- Issue sqN=20 then sqN=8 back-to-back; branch sqN=10 two cycles later:
  - Only tag(sqN=8) is woken.
  - OUT_inflight drops by 1 in the flush cycle.
- Branch sqN=7 while port 0 presents sqN=7: the uop is kept and issued (equal is not younger).
- Assert rst for 1 cycle while 3 ops are in flight: all outputs reset immediately, and no wake occurs afterwards.
